// File: rtl/lif_scheduler.sv
// Time-multiplexed LIF neuron scheduler: fetches one current per neuron over a
// valid/ready handshake, updates U' = I + (U >> BETA_SHIFT) and publishes spikes.
module lif_scheduler #(
  parameter int N_NEURONS   = 4,
  parameter int W           = 8,
  parameter int THRESH_INIT = 127,
  parameter int BETA_SHIFT  = 1,
  parameter int REFRACT     = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         cur_req,
  output logic [$clog2(N_NEURONS)-1:0] cur_idx,
  input  logic                         cur_valid,
  input  logic [W-1:0]                 cur_data,
  input  logic                         cfg_we,
  input  logic [W-1:0]                 cfg_thresh,
  output logic                         busy,
  output logic                         done,
  output logic [N_NEURONS-1:0]         spike_vec,
  output logic [W-1:0]                 threshold
);

  localparam int IW = $clog2(N_NEURONS);
  localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_UPDATE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]           state;
  logic [W-1:0]         u    [N_NEURONS];
  logic [RW-1:0]        refr [N_NEURONS];
  logic [W-1:0]         cur_lat;
  logic [N_NEURONS-1:0] spk_work;
  logic [N_NEURONS-1:0] spk_next;
  logic [W:0]           sum;
  logic [W-1:0]         sum_sat;
  logic                 in_refr;
  logic                 fire;
  logic                 last;

  always_comb begin
    sum      = {1'b0, cur_lat} + {1'b0, (u[cur_idx] >> BETA_SHIFT)};
    sum_sat  = sum[W] ? '1 : sum[W-1:0];
    in_refr  = (refr[cur_idx] != '0);
    fire     = !in_refr && (sum_sat >= threshold);
    last     = (cur_idx == IW'(N_NEURONS - 1));
    // Fold the neuron being updated now into the vector so the last neuron's
    // spike is already visible when spike_vec is published.
    spk_next = spk_work;
    if (state == S_UPDATE && fire)
      spk_next[cur_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_idx   <= '0;
      cur_lat   <= '0;
      spk_work  <= '0;
      spike_vec <= '0;
      threshold <= W'(THRESH_INIT);
      for (int unsigned i = 0; i < N_NEURONS; i++) begin
        u[i]    <= '0;
        refr[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          if (cfg_we)
            threshold <= cfg_thresh;
          if (start) begin
            state    <= S_FETCH;
            cur_idx  <= '0;
            spk_work <= '0;
          end
        end
        S_FETCH: begin
          if (cur_valid) begin
            cur_lat <= cur_data;
            state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          spk_work <= spk_next;
          if (in_refr) begin
            refr[cur_idx] <= refr[cur_idx] - 1'b1;
            u[cur_idx]    <= '0;
          end else if (fire) begin
            u[cur_idx]    <= '0;
            refr[cur_idx] <= RW'(REFRACT);
          end else begin
            u[cur_idx]    <= sum_sat;
          end
          if (last) begin
            state     <= S_DONE;
            spike_vec <= spk_next;
          end else begin
            cur_idx <= cur_idx + 1'b1;
            state   <= S_FETCH;
          end
        end
        default: begin
          state   <= S_IDLE;
          cur_idx <= '0;
        end
      endcase
    end
  end

  assign cur_req = (state == S_FETCH);
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);

endmodule

// File: tb/tb_lif_scheduler.sv
// Self-checking bench for lif_scheduler: randomized currents and stalls compared
// against an arithmetic LIF model of the neuron population.
module tb_lif_scheduler;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int BETA = 1;
  localparam int REF  = 2;
  localparam int TH0  = 127;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         cur_req;
  logic [1:0]   cur_idx;
  logic         cur_valid = 1'b0;
  logic [W-1:0] cur_data = '0;
  logic         cfg_we = 1'b0;
  logic [W-1:0] cfg_thresh = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] spike_vec;
  logic [W-1:0] threshold;

  int n_pass  = 0;
  int n_total = 0;

  int mu [N];
  int mr [N];
  int mthr;
  int idx_trace [$];

  lif_scheduler #(
    .N_NEURONS(N), .W(W), .THRESH_INIT(TH0), .BETA_SHIFT(BETA), .REFRACT(REF)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cur_req(cur_req), .cur_idx(cur_idx),
    .cur_valid(cur_valid), .cur_data(cur_data), .cfg_we(cfg_we),
    .cfg_thresh(cfg_thresh), .busy(busy), .done(done), .spike_vec(spike_vec),
    .threshold(threshold)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mu[i] = 0;
      mr[i] = 0;
    end
    mthr = TH0;
  endfunction

  function automatic logic [N-1:0] model_step(input logic [W-1:0] c [N]);
    logic [N-1:0] s = '0;
    int sum;
    for (int k = 0; k < N; k++) begin
      if (mr[k] > 0) begin
        mr[k] = mr[k] - 1;
        mu[k] = 0;
      end else begin
        sum = int'(c[k]) + mu[k] / (1 << BETA);
        if (sum > 255) sum = 255;
        if (sum >= mthr) begin
          s[k]  = 1'b1;
          mu[k] = 0;
          mr[k] = REF;
        end else begin
          mu[k] = sum;
        end
      end
    end
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cur_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // Runs one timestep; returns the cycle (relative to the start cycle) of done.
  task automatic run_step(input logic [W-1:0] c [N], input int s_idx, input int s_n,
                          input bit do_cfg, input logic [W-1:0] cfg_v, input bit poke,
                          output int done_k, output logic [N-1:0] spk);
    int left = s_n;
    for (int w = 0; w < 20 && busy; w++) begin
      @(posedge clk); #1;
    end
    idx_trace.delete();
    start = 1'b1;
    if (do_cfg) begin
      cfg_we = 1'b1;
      cfg_thresh = cfg_v;
    end
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    done_k = -1;
    spk = 'x;
    for (int k = 1; k <= 200; k++) begin
      if (done) begin
        done_k = k;
        spk = spike_vec;
        break;
      end
      idx_trace.push_back(int'(cur_idx));
      if (cur_req && int'(cur_idx) == s_idx && left > 0) begin
        cur_valid = 1'b0;
        left--;
      end else begin
        cur_valid = 1'b1;
      end
      cur_data = cur_req ? c[cur_idx] : W'($urandom);
      start  = poke && (k == 3 || k == 6);
      cfg_we = poke && (k == 3 || k == 6);
      cfg_thresh = 8'd5;
      @(posedge clk); #1;
    end
    cur_valid = 1'b0; start = 1'b0; cfg_we = 1'b0;
  endtask

  function automatic bit trace_ok(input int s_idx, input int s_n);
    int e [$];
    for (int i = 0; i < N; i++) begin
      for (int r = 0; r < 1 + ((i == s_idx) ? s_n : 0); r++) e.push_back(i);
      e.push_back(i);
    end
    if (e.size() != idx_trace.size()) return 1'b0;
    foreach (e[i]) if (e[i] != idx_trace[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (spike_vec !== 4'b0000) $display("FAIL reset_spike got=%b exp=0000", spike_vec); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done got=%b exp=0", done); else n_pass++;
    n_total++; if (cur_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", cur_req); else n_pass++;
    n_total++; if (cur_idx !== 2'd0) $display("FAIL reset_idx got=%0d exp=0", cur_idx); else n_pass++;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (threshold !== 8'd127) $display("FAIL reset_thresh got=%0d exp=127", threshold); else n_pass++;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_leak_spike();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk;
    do_reset();
    c = '{8'd64, 8'd0, 8'd0, 8'd0};
    for (int s = 1; s <= 10; s++) begin
      run_step(c, -1, 0, 1'b0, '0, 1'b0, dk, spk);
      exp = model_step(c);
      n_total++; if (spk !== exp) $display("FAIL leak_step%0d got=%b exp=%b", s, spk, exp); else n_pass++;
      n_total++; if (dk != 9) $display("FAIL leak_lat%0d got=%0d exp=9", s, dk); else n_pass++;
      if (s == 7) begin
        n_total++; if (spk !== 4'b0001) $display("FAIL leak_fire7 got=%b exp=0001", spk); else n_pass++;
      end
    end
  endtask

  task automatic test_clamp();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk;
    do_reset();
    cfg_we = 1'b1; cfg_thresh = 8'd255;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    mthr = 255;
    n_total++; if (threshold !== 8'd255) $display("FAIL clamp_cfg got=%0d exp=255", threshold); else n_pass++;
    c = '{8'd0, 8'd200, 8'd0, 8'd0};
    for (int s = 1; s <= 2; s++) begin
      run_step(c, -1, 0, 1'b0, '0, 1'b0, dk, spk);
      exp = model_step(c);
      n_total++; if (spk !== exp) $display("FAIL clamp_step%0d got=%b exp=%b", s, spk, exp); else n_pass++;
    end
    n_total++; if (spk !== 4'b0010) $display("FAIL clamp_fire got=%b exp=0010", spk); else n_pass++;
  endtask

  task automatic test_timing();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk;
    do_reset();
    foreach (c[i]) c[i] = W'($urandom);
    run_step(c, -1, 0, 1'b0, '0, 1'b0, dk, spk);
    exp = model_step(c);
    n_total++; if (dk != 9) $display("FAIL timing_lat got=%0d exp=9", dk); else n_pass++;
    n_total++; if (trace_ok(-1, 0) !== 1'b1) $display("FAIL timing_idx got_len=%0d exp_len=8", idx_trace.size()); else n_pass++;
    n_total++; if (spk !== exp) $display("FAIL timing_spk got=%b exp=%b", spk, exp); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (done !== 1'b0) $display("FAIL timing_pulse got=%b exp=0", done); else n_pass++;
    n_total++; if (spike_vec !== exp) $display("FAIL timing_hold got=%b exp=%b", spike_vec, exp); else n_pass++;
  endtask

  task automatic test_stall();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk;
    do_reset();
    foreach (c[i]) c[i] = W'($urandom_range(100, 255));
    run_step(c, 2, 5, 1'b0, '0, 1'b0, dk, spk);
    exp = model_step(c);
    n_total++; if (dk != 14) $display("FAIL stall_lat got=%0d exp=14", dk); else n_pass++;
    n_total++; if (trace_ok(2, 5) !== 1'b1) $display("FAIL stall_idx got_len=%0d exp_len=13", idx_trace.size()); else n_pass++;
    n_total++; if (spk !== exp) $display("FAIL stall_spk got=%b exp=%b", spk, exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk;
    do_reset();
    c = '{8'd200, 8'd200, 8'd200, 8'd200};
    run_step(c, -1, 0, 1'b0, '0, 1'b0, dk, spk);
    exp = model_step(c);
    n_total++; if (spk !== exp) $display("FAIL rmid_pre got=%b exp=%b", spk, exp); else n_pass++;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cur_valid = 1'b1; cur_data = 8'd200;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cur_valid = 1'b0;
    model_reset();
    n_total++; if (busy !== 1'b0) $display("FAIL rmid_busy got=%b exp=0", busy); else n_pass++;
    n_total++; if (spike_vec !== 4'b0000) $display("FAIL rmid_spike got=%b exp=0000", spike_vec); else n_pass++;
    n_total++; if (cur_req !== 1'b0) $display("FAIL rmid_req got=%b exp=0", cur_req); else n_pass++;
    c = '{8'd130, 8'd10, 8'd127, 8'd126};
    run_step(c, -1, 0, 1'b0, '0, 1'b0, dk, spk);
    exp = model_step(c);
    n_total++; if (spk !== 4'b0101) $display("FAIL rmid_fresh got=%b exp=0101", spk); else n_pass++;
    n_total++; if (dk != 9) $display("FAIL rmid_lat got=%0d exp=9", dk); else n_pass++;
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    int dk, extra_done, busy_cyc;
    do_reset();
    foreach (c[i]) c[i] = W'($urandom_range(0, 140));
    run_step(c, -1, 0, 1'b0, '0, 1'b1, dk, spk);
    exp = model_step(c);
    n_total++; if (dk != 9) $display("FAIL busy_lat got=%0d exp=9", dk); else n_pass++;
    n_total++; if (spk !== exp) $display("FAIL busy_spk got=%b exp=%b", spk, exp); else n_pass++;
    n_total++; if (threshold !== 8'd127) $display("FAIL busy_thresh got=%0d exp=127", threshold); else n_pass++;
    extra_done = 0; busy_cyc = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done) extra_done++;
      if (busy) busy_cyc++;
    end
    n_total++; if (extra_done != 0) $display("FAIL busy_dones got=%0d exp=0", extra_done); else n_pass++;
    n_total++; if (busy_cyc != 0) $display("FAIL busy_restart got=%0d exp=0", busy_cyc); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] c [N];
    logic [N-1:0] spk, exp;
    logic [W-1:0] tv;
    int dk, si, sn;
    bit cfg;
    do_reset();
    for (int s = 0; s < 20; s++) begin
      foreach (c[i]) c[i] = W'($urandom_range(0, 255));
      si  = $urandom_range(0, 3);
      sn  = $urandom_range(0, 3);
      cfg = ($urandom_range(0, 3) == 0);
      tv  = W'($urandom_range(100, 255));
      run_step(c, si, sn, cfg, tv, 1'b0, dk, spk);
      if (cfg) mthr = int'(tv);
      exp = model_step(c);
      n_total++; if (spk !== exp) $display("FAIL rand_spk%0d got=%b exp=%b", s, spk, exp); else n_pass++;
      n_total++; if (dk != 9 + sn) $display("FAIL rand_lat%0d got=%0d exp=%0d", s, dk, 9 + sn); else n_pass++;
      n_total++; if (int'(threshold) != mthr) $display("FAIL rand_thr%0d got=%0d exp=%0d", s, threshold, mthr); else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_leak_spike();
    test_clamp();
    test_timing();
    test_stall();
    test_reset_mid();
    test_busy_ignore();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
